fec_fabric_pkt_gen: RTL

Synthesisable Ethernet frame generator driving a pipelined WB fabric source port (2-bit adr, 16-bit dat, 2-bit sel) into the FEC encoder/decoder sink.
Next generation of the software packet source used on the FEC bench:
- parametrised length limit, stream count, ack timeout and seed;
- hardware gap, frame-count and error handling.
Used for on-chip stress and loopback of xwb_fec.

---
 rtl/fec_pkt_gen_pkg.sv | 47 ++++
 rtl/fec_lfsr16.sv | 28 ++
 rtl/fec_fabric_pkt_gen.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fec_pkt_gen_pkg.sv
// Shared types and constants for the FEC fabric packet generator.
// Holds the fabric record types, the FSM state enum and the length clamp.
package fec_pkt_gen_pkg;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [1:0]  sel;
        logic [1:0]  adr;
        logic [15:0] dat;
    } t_wrf_source_out;

    typedef struct packed {
        logic stall;
        logic ack;
    } t_wrf_source_in;

    localparam int unsigned c_hdr_words = 7;
    localparam int unsigned c_min_len   = 46;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
    localparam logic [15:0] c_lfsr_taps = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_DRAIN,
        S_GAP
    } t_gen_state;

    function automatic logic [15:0] clamp_len(
        input logic [15:0] len,
        input int unsigned max_len
    );
        logic [15:0] r;
        r = len;
        if ({16'b0, len} < c_min_len) begin
            r = 16'(c_min_len);
        end else if ({16'b0, len} > max_len) begin
            r = 16'(max_len);
        end
        return r;
    endfunction

endpackage

// File: rtl/fec_lfsr16.sv
// 16-bit Fibonacci LFSR payload source.
// Ports: load_i reloads seed_i, en_i advances one step, q_o is the state.
module fec_lfsr16
    import fec_pkt_gen_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [15:0] seed_i,
    output logic [15:0] q_o
);

    logic [15:0] q_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q <= '0;
        end else if (load_i) begin
            q_q <= seed_i;
        end else if (en_i) begin
            q_q <= {q_q[14:0], ^(q_q & c_lfsr_taps)};
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/fec_fabric_pkt_gen.sv
// Ethernet frame generator driving a pipelined WB fabric source port.
// Ports: cfg_* frame setup, start_i/stop_i control, src_* fabric, status outs.
module fec_fabric_pkt_gen
    import fec_pkt_gen_pkg::*;
#(
    parameter int unsigned g_num_streams = 1,
    parameter int unsigned g_max_len     = 1500,
    parameter logic [15:0] g_lfsr_seed   = 16'hACE1,
    parameter int unsigned g_ack_timeout = 1024,
    parameter int unsigned g_gap_width   = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [47:0]            cfg_dst_mac_i,
    input  logic [47:0]            cfg_src_mac_i,
    input  logic [15:0]            cfg_len_i,
    input  logic [g_gap_width-1:0] cfg_gap_i,
    input  logic [31:0]            cfg_count_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    output logic                   src_cyc_o,
    output logic                   src_stb_o,
    output logic                   src_we_o,
    output logic [1:0]             src_sel_o,
    output logic [1:0]             src_adr_o,
    output logic [15:0]            src_dat_o,
    input  logic                   src_stall_i,
    input  logic                   src_ack_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [31:0]            frame_cnt_o,
    output logic [31:0]            stall_cnt_o,
    output logic                   timeout_o
);

    localparam int unsigned c_tw = $clog2(g_ack_timeout + 1);
    localparam logic [c_tw-1:0] c_tmo_last = c_tw'(g_ack_timeout - 1);
    localparam logic [2:0] c_stream_last = 3'(g_num_streams - 1);
    localparam logic [15:0] c_hdr_last = 16'(c_hdr_words - 1);

    t_gen_state             state_q;
    logic                   cyc_q;
    logic                   stb_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   timeout_q;
    logic                   stop_seen_q;
    logic [47:0]            dst_q;
    logic [47:3]            src_q;
    logic [15:0]            len_q;
    logic [31:0]            count_q;
    logic [g_gap_width-1:0] gap_q;
    logic [g_gap_width-1:0] gcnt_q;
    logic [15:0]            widx_q;
    logic [2:0]             stream_q;
    logic [15:0]            out_q;
    logic [15:0]            out_d;
    logic [c_tw-1:0]        tmo_q;
    logic [31:0]            frame_cnt_q;
    logic [31:0]            stall_cnt_q;

    t_wrf_source_out src_out;
    t_wrf_source_in  src_in;

    logic        accept;
    logic        ack_ok;
    logic        lfsr_load;
    logic        lfsr_en;
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_seed;
    logic [15:0] pay_last;
    logic        last_odd;
    logic        gap_done;
    logic [15:0] hdr_word;

    // Low MAC bits are replaced by the stream index.
    logic unused_src_bits;
    assign unused_src_bits = ^cfg_src_mac_i[2:0];

    assign src_in = '{stall: src_stall_i, ack: src_ack_i};

    assign accept = stb_q & ~src_in.stall;
    // A stray ack with nothing outstanding must not wrap the counter.
    assign ack_ok = src_in.ack & (out_q != '0);

    always_comb begin
        out_d = out_q;
        unique case ({accept, ack_ok})
            2'b10:   out_d = out_q + 16'd1;
            2'b01:   out_d = out_q - 16'd1;
            default: out_d = out_q;
        endcase
    end

    assign lfsr_seed = g_lfsr_seed ^ {13'b0, stream_q};
    assign lfsr_load = (state_q == S_HDR) && accept && (widx_q == c_hdr_last);
    assign lfsr_en   = (state_q == S_PAY) && accept;

    fec_lfsr16 u_lfsr (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .load_i  (lfsr_load),
        .en_i    (lfsr_en),
        .seed_i  (lfsr_seed),
        .q_o     (lfsr_q)
    );

    assign pay_last = (len_q - 16'd1) >> 1;
    assign last_odd = (state_q == S_PAY) && (widx_q == pay_last) && len_q[0];
    assign gap_done = (gap_q == '0) ||
                      (gcnt_q == gap_q - g_gap_width'(1));

    always_comb begin
        hdr_word = len_q;
        unique case (widx_q[2:0])
            3'd0:    hdr_word = dst_q[47:32];
            3'd1:    hdr_word = dst_q[31:16];
            3'd2:    hdr_word = dst_q[15:0];
            3'd3:    hdr_word = src_q[47:32];
            3'd4:    hdr_word = src_q[31:16];
            3'd5:    hdr_word = {src_q[15:3], stream_q};
            default: hdr_word = len_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            stop_seen_q <= 1'b0;
            dst_q       <= '0;
            src_q       <= '0;
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            gcnt_q      <= '0;
            widx_q      <= '0;
            stream_q    <= '0;
            out_q       <= '0;
            tmo_q       <= '0;
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            if (stb_q && src_in.stall && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (stop_i && (state_q != S_IDLE)) begin
                stop_seen_q <= 1'b1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q     <= S_HDR;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        busy_q      <= 1'b1;
                        dst_q       <= cfg_dst_mac_i;
                        src_q       <= cfg_src_mac_i[47:3];
                        len_q       <= clamp_len(cfg_len_i, g_max_len);
                        count_q     <= cfg_count_i;
                        gap_q       <= cfg_gap_i;
                        widx_q      <= '0;
                        stream_q    <= '0;
                        out_q       <= '0;
                        frame_cnt_q <= '0;
                        stall_cnt_q <= '0;
                        timeout_q   <= 1'b0;
                        stop_seen_q <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (accept) begin
                        if (widx_q == c_hdr_last) begin
                            state_q <= S_PAY;
                            widx_q  <= '0;
                        end else begin
                            widx_q <= widx_q + 16'd1;
                        end
                    end
                end
                S_PAY: begin
                    if (accept) begin
                        if (widx_q == pay_last) begin
                            state_q <= S_DRAIN;
                            stb_q   <= 1'b0;
                            tmo_q   <= '0;
                        end else begin
                            widx_q <= widx_q + 16'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((out_q == '0) || (tmo_q == c_tmo_last)) begin
                        state_q <= S_GAP;
                        cyc_q   <= 1'b0;
                        gcnt_q  <= '0;
                        // Late acks belong to an abandoned cycle.
                        out_q   <= '0;
                        if (out_q != '0) begin
                            timeout_q <= 1'b1;
                        end
                        if (frame_cnt_q != '1) begin
                            frame_cnt_q <= frame_cnt_q + 32'd1;
                        end
                        stream_q <= (stream_q == c_stream_last) ?
                                    3'd0 : stream_q + 3'd1;
                    end else begin
                        tmo_q <= tmo_q + c_tw'(1);
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        if (stop_seen_q ||
                            ((count_q != '0) && (frame_cnt_q == count_q))) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_HDR;
                            cyc_q   <= 1'b1;
                            stb_q   <= 1'b1;
                            widx_q  <= '0;
                        end
                    end else begin
                        gcnt_q <= gcnt_q + g_gap_width'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        src_out     = '0;
        src_out.cyc = cyc_q;
        src_out.stb = stb_q;
        src_out.we  = 1'b1;
        src_out.adr = 2'b00;
        if (stb_q) begin
            if (state_q == S_HDR) begin
                src_out.sel = 2'b11;
                src_out.dat = hdr_word;
            end else begin
                src_out.sel = last_odd ? 2'b10 : 2'b11;
                src_out.dat = {lfsr_q[15:8], last_odd ? 8'h00 : lfsr_q[7:0]};
            end
        end
    end

    assign src_cyc_o   = src_out.cyc;
    assign src_stb_o   = src_out.stb;
    assign src_we_o    = src_out.we;
    assign src_sel_o   = src_out.sel;
    assign src_adr_o   = src_out.adr;
    assign src_dat_o   = src_out.dat;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_cnt_o = frame_cnt_q;
    assign stall_cnt_o = stall_cnt_q;
    assign timeout_o   = timeout_q;

endmodule
